// File: rtl/demux_1_8_reg_pkg.sv
// Shared definitions for the registered 1-to-8 demultiplexer.
// Holds the lane-count, select-width and data-width constants it shares with the
// 8:1 result selector, the per-lane state encoding, and the one-hot select decode.
package demux_1_8_reg_pkg;

  localparam int ALU_LANES  = 8;
  localparam int ALU_SEL_W  = 3;
  localparam int ALU_DATA_W = 64;

  typedef enum logic {
    LANE_EMPTY = 1'b0,
    LANE_FULL  = 1'b1
  } lane_state_e;

  function automatic logic [ALU_LANES-1:0] sel_onehot(input logic [ALU_SEL_W-1:0] sel);
    logic [ALU_LANES-1:0] oh;
    oh = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/demux_1_8_reg_lane.sv
// One output lane of the demultiplexer: a holding register plus its valid flop.
// Ports:
//   clock    rising-edge clock
//   reset_n  synchronous active-low reset (clears state and data)
//   wr_en    load wr_data this cycle (only asserted when the lane can accept)
//   wr_data  word to hold
//   ack      consumer takes the held word this cycle
//   data     held word; keeps its last value while the lane is EMPTY
//   valid    lane holds an unconsumed word
module demux_1_8_reg_lane
  import demux_1_8_reg_pkg::*;
#(
  parameter int WIDTH = ALU_DATA_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             ack,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  lane_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= LANE_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    unique case (state_q)
      LANE_EMPTY: begin
        // An ack on an empty lane is ignored.
        if (wr_en) begin
          state_d = LANE_FULL;
          data_d  = wr_data;
        end
      end
      LANE_FULL: begin
        // A write here is only possible together with an ack: refill without a bubble.
        if (wr_en) begin
          data_d = wr_data;
        end else if (ack) begin
          state_d = LANE_EMPTY;
        end
      end
      default: state_d = LANE_EMPTY;
    endcase
  end

  assign data  = data_q;
  assign valid = (state_q == LANE_FULL);

endmodule

// File: rtl/demux_1_8_reg.sv
// Registered 1-to-8 demultiplexer: the write-side counterpart of the 8:1 result
// selector. One word per cycle is steered to the lane named by in_select and held
// there until that lane's consumer acks it. Backpressure is per lane.
// Ports:
//   clock        rising-edge clock
//   reset_n      synchronous active-low reset
//   in_data      word to distribute
//   in_select    destination lane 0..7
//   in_valid     in_data/in_select valid this cycle
//   in_ready     addressed lane can accept this cycle (combinational)
//   out_data     lane k data at bits [k*WIDTH +: WIDTH]
//   out_valid    lane k holds an unconsumed word
//   out_ack      consumer k takes its word this cycle
//   stall_count  saturating count of cycles with in_valid=1 and in_ready=0
module demux_1_8_reg
  import demux_1_8_reg_pkg::*;
#(
  parameter int WIDTH   = ALU_DATA_W,
  parameter int STALL_W = 16
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [ALU_SEL_W-1:0]       in_select,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [ALU_LANES*WIDTH-1:0] out_data,
  output logic [ALU_LANES-1:0]       out_valid,
  input  logic [ALU_LANES-1:0]       out_ack,
  output logic [STALL_W-1:0]         stall_count
);

  function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
    return (&v) ? v : v + {{(STALL_W-1){1'b0}}, 1'b1};
  endfunction

  logic [ALU_LANES-1:0] sel_oh;
  logic [ALU_LANES-1:0] wr_en;
  logic [STALL_W-1:0]   stall_q, stall_d;

  // in_ready is driven from in_select even when in_valid is low.
  assign in_ready = ~out_valid[in_select] | out_ack[in_select];
  assign sel_oh   = in_valid ? sel_onehot(in_select) : '0;
  assign wr_en    = sel_oh & {ALU_LANES{in_ready}};

  for (genvar k = 0; k < ALU_LANES; k++) begin : g_lane
    demux_1_8_reg_lane #(
      .WIDTH(WIDTH)
    ) u_lane (
      .clock  (clock),
      .reset_n(reset_n),
      .wr_en  (wr_en[k]),
      .wr_data(in_data),
      .ack    (out_ack[k]),
      .data   (out_data[k*WIDTH +: WIDTH]),
      .valid  (out_valid[k])
    );
  end

  always_comb begin
    stall_d = stall_q;
    if (in_valid && !in_ready) begin
      stall_d = sat_inc(stall_q);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_count = stall_q;

endmodule

// File: tb/tb_demux_1_8_reg.sv
module tb_demux_1_8_reg;
  import demux_1_8_reg_pkg::*;

  localparam int W  = 64;
  localparam int SW = 16;

  logic           clock = 1'b0;
  logic           reset_n;
  logic [W-1:0]   in_data;
  logic [2:0]     in_select;
  logic           in_valid;
  logic           in_ready;
  logic [8*W-1:0] out_data;
  logic [7:0]     out_valid;
  logic [7:0]     out_ack;
  logic [SW-1:0]  stall_count;

  demux_1_8_reg #(.WIDTH(W), .STALL_W(SW)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_data    (in_data),
    .in_select  (in_select),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ack    (out_ack),
    .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0]     vld;
    logic [8*W-1:0] dat;
    logic [SW-1:0]  stall;
  } exp_t;

  typedef struct packed {
    logic       v;
    logic [2:0] s;
    logic [W-1:0] d;
    logic [7:0] a;
    logic       rdy;
    logic [7:0] ov;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[19];

  // Reference model state
  logic [7:0]     m_vld;
  logic [8*W-1:0] m_dat;
  logic [SW-1:0]  m_stall;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [8*W-1:0] act, input logic [8*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Advance the model by one clock edge for the given inputs.
  task automatic model_edge(input logic v, input logic [2:0] s, input logic [W-1:0] d,
                            input logic [7:0] a, input logic rn);
    logic rdy;
    rdy = ~m_vld[s] | a[s];
    if (!rn) begin
      m_vld   = '0;
      m_dat   = '0;
      m_stall = '0;
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (v && rdy && s == k) begin
          m_vld[k] = 1'b1;
          m_dat[k*W +: W] = d;
        end else if (a[k]) begin
          m_vld[k] = 1'b0;
        end
      end
      if (v && !rdy && m_stall != {SW{1'b1}}) m_stall = m_stall + 1'b1;
    end
  endtask

  // Drive one cycle; when do_chk is set the expected outputs are queued and compared after the edge.
  task automatic step(input logic v, input logic [2:0] s, input logic [W-1:0] d,
                      input logic [7:0] a, input logic rn, input bit do_chk);
    exp_t e;
    in_valid = v; in_select = s; in_data = d; out_ack = a; reset_n = rn;
    model_edge(v, s, d, a, rn);
    if (do_chk) exp_q.push_back('{vld: m_vld, dat: m_dat, stall: m_stall});
    @(posedge clock);
    #1;
    if (do_chk) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_empty got=0 want=1");
      end else begin
        e = exp_q.pop_front();
        chk("out_valid", {504'd0, out_valid}, {504'd0, e.vld});
        chk("out_data", out_data, e.dat);
        chk("stall_count", {496'd0, stall_count}, {496'd0, e.stall});
      end
    end
  endtask

  initial begin
    m_vld = '0; m_dat = '0; m_stall = '0;
    in_valid = 1'b1; in_select = '0; in_data = '1; out_ack = '0; reset_n = 1'b0;

    // Table: rotating fill, backpressure, idle, ack-refill, drain, spurious ack
    for (int k = 0; k < 8; k++) begin
      logic [8:0] ovm;
      ovm = (9'd1 << (k + 1)) - 9'd1;
      tbl[k] = '{v: 1'b1, s: 3'(k), d: 64'h1111_1111_1111_1111 * (k + 1), a: 8'h00,
                 rdy: 1'b1, ov: ovm[7:0]};
    end
    for (int k = 8; k < 13; k++)
      tbl[k] = '{v: 1'b1, s: 3'd3, d: 64'hDEAD, a: 8'h00, rdy: 1'b0, ov: 8'hFF};
    tbl[13] = '{v: 1'b0, s: 3'd3, d: 64'hBEEF, a: 8'h00, rdy: 1'b0, ov: 8'hFF};
    tbl[14] = '{v: 1'b1, s: 3'd5, d: 64'hA,    a: 8'h20, rdy: 1'b1, ov: 8'hFF};
    tbl[15] = '{v: 1'b1, s: 3'd5, d: 64'hB,    a: 8'h20, rdy: 1'b1, ov: 8'hFF};
    tbl[16] = '{v: 1'b0, s: 3'd0, d: 64'h0,    a: 8'hFF, rdy: 1'b1, ov: 8'h00};
    tbl[17] = '{v: 1'b1, s: 3'd2, d: 64'h2222_CAFE, a: 8'h00, rdy: 1'b1, ov: 8'h04};
    tbl[18] = '{v: 1'b1, s: 3'd6, d: 64'h6666_F00D, a: 8'hFF, rdy: 1'b1, ov: 8'h40};

    // Reset for two cycles with in_valid high
    step(1'b1, 3'd0, '1, 8'h00, 1'b0, 1'b1);
    step(1'b1, 3'd0, '1, 8'h00, 1'b0, 1'b1);
    in_valid = 1'b1; in_select = 3'd0; out_ack = 8'h00; reset_n = 1'b1;
    #1;
    chk("reset_in_ready", {511'd0, in_ready}, {511'd0, 1'b1});

    for (int i = 0; i < 19; i++) begin
      in_valid = tbl[i].v; in_select = tbl[i].s; in_data = tbl[i].d; out_ack = tbl[i].a;
      reset_n = 1'b1;
      #1;
      chk($sformatf("in_ready[%0d]", i), {511'd0, in_ready}, {511'd0, tbl[i].rdy});
      step(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].a, 1'b1, 1'b1);
      chk($sformatf("tbl_ov[%0d]", i), {504'd0, out_valid}, {504'd0, tbl[i].ov});
    end
    chk("lane3_held", {448'd0, out_data[3*W +: W]}, {448'd0, 64'h4444_4444_4444_4444});
    chk("lane5_refill", {448'd0, out_data[5*W +: W]}, {448'd0, 64'hB});
    chk("stall_after_bp", {496'd0, stall_count}, {496'd0, 16'd5});

    // Saturation: lane 6 full, no ack, 2^16+3 stalled cycles
    for (int n = 0; n < 65536 + 2; n++) step(1'b1, 3'd6, 64'h0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 3'd6, 64'h0, 8'h00, 1'b1, 1'b1);
    chk("stall_saturated", {496'd0, stall_count}, {496'd0, 16'hFFFF});
    chk("lane6_held", {448'd0, out_data[6*W +: W]}, {448'd0, 64'h6666_F00D});

    // Fill more lanes, then reset mid-stream with writes and acks pending
    step(1'b1, 3'd0, 64'h0123_4567_89AB_CDEF, 8'h00, 1'b1, 1'b1);
    step(1'b1, 3'd1, 64'hFEDC_BA98_7654_3210, 8'h00, 1'b1, 1'b1);
    step(1'b1, 3'd2, 64'h5555_AAAA_5555_AAAA, 8'h40, 1'b0, 1'b1);
    chk("mid_reset_valid", {504'd0, out_valid}, 512'd0);
    chk("mid_reset_data", out_data, 512'd0);
    chk("mid_reset_stall", {496'd0, stall_count}, 512'd0);
    in_valid = 1'b1; in_select = 3'd1; out_ack = 8'h00; reset_n = 1'b1;
    #1;
    chk("post_reset_ready", {511'd0, in_ready}, {511'd0, 1'b1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
